// File: rtl/sipo_frame_ctrl.sv
// Sequencing controller for an external SIPO: clears it on frame start, gates
// WIDTH serial bits in, then captures the parallel word into a one-entry
// valid/ready output buffer. Reports frame aborts and overruns.
module sipo_frame_ctrl #(
    parameter int WIDTH      = 4,
    parameter int CNT_W      = $clog2(WIDTH + 1),
    parameter bit CONTINUOUS = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_in,
    input  logic             bit_valid,
    input  logic             start,
    input  logic [WIDTH-1:0] sr_q,
    output logic             sr_din,
    output logic             shift_en,
    output logic             sr_clear,
    output logic [WIDTH-1:0] p_data,
    output logic             p_valid,
    input  logic             p_ready,
    output logic             busy,
    output logic             abort,
    output logic             overrun,
    input  logic             clr_ovr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   p_data_q, p_data_d;
    logic               p_valid_q, p_valid_d;
    logic               abort_q, abort_d;
    logic               overrun_q, overrun_d;
    logic               ovr_set;
    logic               buf_free;

    // The buffer can take a new word if empty or being drained on this edge.
    assign buf_free = !p_valid_q || p_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            p_data_q  <= '0;
            p_valid_q <= 1'b0;
            abort_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            p_data_q  <= p_data_d;
            p_valid_q <= p_valid_d;
            abort_q   <= abort_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        p_data_d  = p_data_q;
        p_valid_d = p_valid_q;
        abort_d   = 1'b0;
        ovr_set   = 1'b0;
        shift_en  = 1'b0;
        sr_clear  = 1'b0;

        if (p_valid_q && p_ready) begin
            p_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    sr_clear = 1'b1;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                // A restart beats a coincident bit: the partial frame is dropped.
                if (start) begin
                    sr_clear = 1'b1;
                    cnt_d    = '0;
                    abort_d  = 1'b1;
                end else if (bit_valid) begin
                    shift_en = 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        cnt_d   = '0;
                        state_d = LOAD;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            LOAD, HOLD: begin
                if (bit_valid) begin
                    ovr_set = 1'b1;
                end
                if (buf_free) begin
                    p_data_d  = sr_q;
                    p_valid_d = 1'b1;
                    if (CONTINUOUS) begin
                        sr_clear = 1'b1;
                        state_d  = SHIFT;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = HOLD;
                end
            end
            default: state_d = IDLE;
        endcase

        overrun_d = clr_ovr ? 1'b0 : (overrun_q || ovr_set);
    end

    assign sr_din  = a_in;
    assign p_data  = p_data_q;
    assign p_valid = p_valid_q;
    assign busy    = (state_q != IDLE);
    assign abort   = abort_q;
    assign overrun = overrun_q;

endmodule
